vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 10: coordinate width.
- HSTART, 296: first active hcnt.
- HACT, 1024: active pixels per line.
- VSTART, 35: first active vcnt.
- VACT, 768: active lines per frame.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  pixel clock, 65 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- hs_in  in  1  horizontal sync, active-low.
- vs_in  in  1  vertical sync, active-low.
- de  out  1  active-area flag.
- x  out  WIDTH  pixel column.
- y  out  WIDTH  pixel row.
- locked  out  1  timing stable.
- h_total  out  12  measured clocks per line.
- v_total  out  12  measured lines per frame.

Function
REQ-003 hs_in and vs_in SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies (hs_s, vs_s).
REQ-004 The hs edge (hse) SHALL be a one-cycle pulse when hs_s goes from inactive to active.
REQ-005 hcnt (12 bit) SHALL behave as follows:
- Load 0 on hse.
- Otherwise increment.
- Saturate at 4095.
REQ-006 On hse, h_total SHALL load hcnt+1; the first hse after reset SHALL NOT load h_total.
REQ-007 On hse, vcnt (12 bit) SHALL behave as follows:
- Load 0 if vs_s is active now and was inactive at the previous hse; this is the frame-start event (fse).
- Otherwise increment, saturating at 4095.
REQ-008 On fse, v_total SHALL load vcnt+1.
REQ-009 hmis SHALL be set on any hse where hcnt+1 differs from the current h_total, and SHALL clear on fse.
REQ-010 The FSM SHALL have four states, IDLE, ACQ1, ACQ2 and LOCKED, with these transitions:
- IDLE -> ACQ1 on fse.
- ACQ1 -> ACQ2 on fse.
- ACQ2 -> LOCKED on fse if vcnt+1 equals v_total and hmis is 0; otherwise stay in ACQ2.
- LOCKED -> IDLE on fse if vcnt+1 differs from v_total or hmis is 1.
REQ-011 Any state SHALL go to IDLE when hcnt reaches 4095 (sync-loss timeout); this takes priority over fse.
REQ-012 locked SHALL be registered and high exactly while the state is LOCKED.
REQ-013 de, x and y SHALL be registered, one cycle after the hcnt/vcnt values they describe:
- de = locked AND HSTART <= hcnt < HSTART+HACT AND VSTART <= vcnt < VSTART+VACT.
- x = hcnt-HSTART and y = vcnt-VSTART, truncated to WIDTH.
- When de is 0, x and y SHALL be 0.
REQ-014 Input-to-output latency SHALL be 4 clk: 2 synchronizer, 1 edge/counter, 1 output register.
REQ-015 When hse and fse occur in the same cycle, hcnt and vcnt SHALL both load 0, and the FSM SHALL evaluate using the pre-edge vcnt and hmis.

Reset
REQ-016 While rst_n is low, the following SHALL be 0: synchronizers (inactive level), hcnt, vcnt, h_total, v_total, hmis, de, x, y, locked.
REQ-017 While rst_n is low, the state SHALL be IDLE.
REQ-018 After reset deassertion, a minimum of 3 fse SHALL be required before locked rises.

Configuration
REQ-019 Macro VGA_RX_AUTOPOL_EN SHALL select sync polarity handling:
- Defined: per-sync polarity SHALL be the level held for fewer clocks (hs) or fewer lines (vs) over the last full period, re-evaluated each period.
- Defined: sync inputs SHALL be inverted internally when active-high.
- Defined: the FSM SHALL go to IDLE on a polarity change.
- Undefined: both syncs SHALL be fixed active-low, with no extra logic.

Verification
REQ-020 Feed 1344x806 timing (hs low 136 clk, vs low 6 lines), then check:
- locked rises at the 3rd fse.
- h_total = 1344.
- v_total = 806.
REQ-021 While locked, check:
- First de=1 at hcnt 296 of line vcnt 35, with x=0, y=0.
- Last de=1 with x=1023, y=767.
- Exactly 786432 de cycles per frame.
REQ-022 While locked, shorten one line to 1343 clk -> locked falls at the next fse, and relocks after 3 further good fse.
REQ-023 Stop hs_in for 4096 clk -> locked=0 and state IDLE; restore hs_in -> relock occurs.
REQ-024 Assert rst_n low mid-frame -> all outputs are 0 immediately (asynchronous); after release, 3 fse are required to relock.
REQ-025 With VGA_RX_AUTOPOL_EN defined, drive inverted (active-high) syncs -> locked=1 and x/y identical to the active-low case; without the macro, locked stays 0.

Source files
------------

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: measures incoming VGA sync timing, locks onto it and emits de/x/y.
// Define VGA_RX_AUTOPOL_EN to detect sync polarity instead of assuming active-low.
module vga_sync_rx #(
  parameter int WIDTH  = 10,
  parameter int HSTART = 296,
  parameter int HACT   = 1024,
  parameter int VSTART = 35,
  parameter int VACT   = 768
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic             de,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             locked,
  output logic [11:0]      h_total,
  output logic [11:0]      v_total
);
  localparam logic [11:0] H_LO = 12'(HSTART);
  localparam logic [11:0] H_HI = 12'(HSTART + HACT);
  localparam logic [11:0] V_LO = 12'(VSTART);
  localparam logic [11:0] V_HI = 12'(VSTART + VACT);
  localparam logic [11:0] SAT  = 12'hFFF;
  typedef enum logic [1:0] {IDLE, ACQ1, ACQ2, LOCKED} state_t;
  state_t state_q;
  logic [1:0] hs_sync_q, hs_sync_d, vs_sync_q, vs_sync_d;
  logic hs_s, vs_s, hse, fse, v_ok, pol_chg;
  logic hs_prev_q, hs_prev_d, vs_hse_q, vs_hse_d, h_seen_q, h_seen_d, hmis_q, hmis_d;
  logic locked_q, de_q, de_d;
  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, h_total_q, h_total_d, v_total_q, v_total_d;
  logic [11:0] hcnt_p1, vcnt_p1;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
`ifdef VGA_RX_AUTOPOL_EN
  logic hneg_q, hneg_d, vneg_q, vneg_d, hr_prev_q, vr_prev_q, hr_rise, vr_rise;
  logic [11:0] hhi_q, hhi_d, hlo_q, hlo_d, vhi_q, vhi_d, vlo_q, vlo_d;
  // Active level is whichever raw level was held shorter over the last period.
  always_comb begin
    hs_sync_d = {hs_sync_q[0], hs_in};
    vs_sync_d = {vs_sync_q[0], vs_in};
    hs_s = hs_sync_q[1] ^ hneg_q;
    vs_s = vs_sync_q[1] ^ vneg_q;
    hr_rise = hs_sync_q[1] & ~hr_prev_q;
    vr_rise = vs_sync_q[1] & ~vr_prev_q;
    hneg_d = hr_rise ? (hhi_q > hlo_q) : hneg_q;
    vneg_d = vr_rise ? (vhi_q > vlo_q) : vneg_q;
    hhi_d = hr_rise ? 12'd0 : (hs_sync_q[1] && hhi_q != SAT) ? hhi_q + 12'd1 : hhi_q;
    hlo_d = hr_rise ? 12'd0 : (!hs_sync_q[1] && hlo_q != SAT) ? hlo_q + 12'd1 : hlo_q;
    vhi_d = vr_rise ? 12'd0 : (hse && vs_sync_q[1] && vhi_q != SAT) ? vhi_q + 12'd1 : vhi_q;
    vlo_d = vr_rise ? 12'd0 : (hse && !vs_sync_q[1] && vlo_q != SAT) ? vlo_q + 12'd1 : vlo_q;
    pol_chg = (hneg_d != hneg_q) || (vneg_d != vneg_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hneg_q <= 1'b1;
      vneg_q <= 1'b1;
      hr_prev_q <= 1'b0;
      vr_prev_q <= 1'b0;
      hhi_q <= '0;
      hlo_q <= '0;
      vhi_q <= '0;
      vlo_q <= '0;
    end else begin
      hneg_q <= hneg_d;
      vneg_q <= vneg_d;
      hr_prev_q <= hs_sync_q[1];
      vr_prev_q <= vs_sync_q[1];
      hhi_q <= hhi_d;
      hlo_q <= hlo_d;
      vhi_q <= vhi_d;
      vlo_q <= vlo_d;
    end
`else
  // Synchronizers carry the inverted syncs, so 1 means active.
  always_comb begin
    hs_sync_d = {hs_sync_q[0], ~hs_in};
    vs_sync_d = {vs_sync_q[0], ~vs_in};
    hs_s = hs_sync_q[1];
    vs_s = vs_sync_q[1];
    pol_chg = 1'b0;
  end
`endif
  assign hse = hs_s & ~hs_prev_q;
  assign fse = hse & vs_s & ~vs_hse_q;
  assign hcnt_p1 = hcnt_q + 12'd1;
  assign vcnt_p1 = vcnt_q + 12'd1;
  assign v_ok = (vcnt_p1 == v_total_q) && !hmis_q;
  always_comb begin
    hs_prev_d = hs_s;
    vs_hse_d = hse ? vs_s : vs_hse_q;
    h_seen_d = h_seen_q | hse;
    hcnt_d = hse ? 12'd0 : (hcnt_q == SAT) ? SAT : hcnt_p1;
    vcnt_d = fse ? 12'd0 : (hse && vcnt_q != SAT) ? vcnt_p1 : vcnt_q;
    h_total_d = (hse && h_seen_q) ? hcnt_p1 : h_total_q;
    v_total_d = fse ? vcnt_p1 : v_total_q;
    hmis_d = fse ? 1'b0 : hmis_q | (hse && hcnt_p1 != h_total_q);
    de_d = locked_q && hcnt_q >= H_LO && hcnt_q < H_HI && vcnt_q >= V_LO && vcnt_q < V_HI;
    x_d = de_d ? WIDTH'(hcnt_q - H_LO) : '0;
    y_d = de_d ? WIDTH'(vcnt_q - V_LO) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_sync_q <= '0;
      vs_sync_q <= '0;
      hs_prev_q <= 1'b0;
      vs_hse_q <= 1'b0;
      h_seen_q <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      h_total_q <= '0;
      v_total_q <= '0;
      hmis_q <= 1'b0;
      de_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      hs_sync_q <= hs_sync_d;
      vs_sync_q <= vs_sync_d;
      hs_prev_q <= hs_prev_d;
      vs_hse_q <= vs_hse_d;
      h_seen_q <= h_seen_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      h_total_q <= h_total_d;
      v_total_q <= v_total_d;
      hmis_q <= hmis_d;
      de_q <= de_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  // Sync-loss timeout and polarity change override any frame-start decision.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      locked_q <= 1'b0;
    end else if (hcnt_q == SAT || pol_chg) begin
      state_q <= IDLE;
      locked_q <= 1'b0;
    end else if (fse)
      case (state_q)
        IDLE: state_q <= ACQ1;
        ACQ1: state_q <= ACQ2;
        ACQ2:
          if (v_ok) begin
            state_q <= LOCKED;
            locked_q <= 1'b1;
          end
        default:
          if (!v_ok) begin
            state_q <= IDLE;
            locked_q <= 1'b0;
          end
      endcase
  assign de = de_q;
  assign x = x_q;
  assign y = y_q;
  assign locked = locked_q;
  assign h_total = h_total_q;
  assign v_total = v_total_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed bench for vga_sync_rx on a scaled-down 100x20 raster.
module tb_vga_sync_rx;
  localparam int W = 10, HST = 12, HAC = 80, VST = 2, VAC = 16;
  localparam int LEN = 100, HSW = 10, NL = 20, VSW = 2;
  logic clk = 0, rst_n = 1, hs_in = 1, vs_in = 1;
  logic de, locked;
  logic [W-1:0] x, y;
  logic [11:0] h_total, v_total;
  int n_chk = 0, n_fail = 0;
  int gh = LEN - 1, gv = NL - 1, gframe = 0, short_row = -1;
  bit gen_on = 0, hs_stop = 0, inv = 0;
  int cnt = 0, zx_bad = 0;
  int c_fgh, c_fgv, c_fx, c_fy, c_lgh, c_lgv, c_lx, c_ly;
  int f_cnt = -1, f_gh = -1, f_gv = -1, f_x = -1, f_y = -1, l_gh = -1, l_gv = -1, l_x = -1, l_y = -1;

  vga_sync_rx #(.WIDTH(W), .HSTART(HST), .HACT(HAC), .VSTART(VST), .VACT(VAC)) dut (
    .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .de(de), .x(x), .y(y),
    .locked(locked), .h_total(h_total), .v_total(v_total)
  );

  initial forever #5 clk = ~clk;

  // Raster generator: gh/gv is the pixel currently driven onto the sync inputs.
  initial forever begin
    @(negedge clk);
    if (gen_on) begin
      if (gh >= ((gv == short_row) ? LEN - 2 : LEN - 1)) begin
        gh = 0;
        gv = (gv == NL - 1) ? 0 : gv + 1;
        if (gv == 0) gframe++;
      end else gh++;
      hs_in = inv ^ (hs_stop || gh >= HSW);
      vs_in = inv ^ (gv >= VSW);
    end
  end

  // Per-frame de statistics, latched at each raster frame start.
  initial forever begin
    @(posedge clk);
    #1;
    if (gh == 0 && gv == 0) begin
      f_cnt = cnt; f_gh = c_fgh; f_gv = c_fgv; f_x = c_fx; f_y = c_fy;
      l_gh = c_lgh; l_gv = c_lgv; l_x = c_lx; l_y = c_ly;
      cnt = 0;
    end
    if (de === 1'b1) begin
      if (cnt == 0) begin c_fgh = gh; c_fgv = gv; c_fx = int'(x); c_fy = int'(y); end
      c_lgh = gh; c_lgv = gv; c_lx = int'(x); c_ly = int'(y);
      cnt++;
    end else if (x != 0 || y != 0) zx_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int t = gframe + n;
    int c = 0;
    while (gframe < t && c < (n + 1) * NL * LEN + 100) begin
      @(negedge clk);
      c++;
    end
    chk("frame_wait", 32'(gframe >= t), 1);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_de_count"}, f_cnt, HAC * VAC);
    chk({tag, "_first_col"}, f_gh, HST + 3);
    chk({tag, "_first_row"}, f_gv, VST);
    chk({tag, "_first_x"}, f_x, 0);
    chk({tag, "_first_y"}, f_y, 0);
    chk({tag, "_last_col"}, l_gh, HST + HAC + 2);
    chk({tag, "_last_row"}, l_gv, VST + VAC - 1);
    chk({tag, "_last_x"}, l_x, HAC - 1);
    chk({tag, "_last_y"}, l_y, VAC - 1);
  endtask

  initial begin
    int c;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_locked", locked, 0);
    chk("rst_h_total", h_total, 0);
    chk("rst_v_total", v_total, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    gen_on = 1;
    wait_frames(1); settle();
    chk("fse1_locked", locked, 0);
    wait_frames(1); settle();
    chk("fse2_locked", locked, 0);
    wait_frames(1);
    chk("pre_fse3_locked", locked, 0);
    settle();
    chk("fse3_locked", locked, 1);
    chk("h_total", h_total, LEN);
    chk("v_total", v_total, NL);
    wait_frames(1); settle();
    chk_frame("frame");
    short_row = 5;
    repeat (LEN * 8) @(negedge clk);
    chk("short_mid_locked", locked, 1);
    short_row = -1;
    wait_frames(1); settle();
    chk("short_fall_locked", locked, 0);
    wait_frames(1); settle();
    chk("short_acq1_locked", locked, 0);
    wait_frames(1); settle();
    chk("short_acq2_locked", locked, 0);
    wait_frames(1); settle();
    chk("short_relock", locked, 1);
    chk("short_h_total", h_total, LEN);
    hs_stop = 1;
    repeat (3000) @(negedge clk);
    chk("stop_early_locked", locked, 1);
    repeat (1400) @(negedge clk);
    chk("stop_timeout_locked", locked, 0);
    chk("stop_timeout_de", de, 0);
    hs_stop = 0;
    wait_frames(5); settle();
    chk("stop_relock", locked, 1);
    chk("stop_h_total", h_total, LEN);
    chk("stop_v_total", v_total, NL);
    c = 0;
    while (!(de === 1'b1 && x > 10) && c < 2 * NL * LEN) begin
      @(negedge clk);
      c++;
    end
    chk("pre_rst_de", de, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_de", de, 0);
    chk("async_rst_x", x, 0);
    chk("async_rst_y", y, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_h_total", h_total, 0);
    chk("async_rst_v_total", v_total, 0);
    repeat (5) @(negedge clk);
    rst_n = 1;
    wait_frames(1); settle();
    chk("rst_fse1_locked", locked, 0);
    wait_frames(1); settle();
    chk("rst_fse2_locked", locked, 0);
    wait_frames(1); settle();
    chk("rst_fse3_locked", locked, 1);
    wait_frames(1); settle();
    chk_frame("rst_frame");
`ifdef VGA_RX_AUTOPOL_EN
    inv = 1;
    wait_frames(8); settle();
    chk("inv_locked", locked, 1);
    wait_frames(1); settle();
    chk_frame("inv_frame");
`endif
    chk("zero_xy_when_idle", zx_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
